// File: rtl/register_file.sv
// RV32I integer register file: 2**ADDR_WIDTH x DATA_WIDTH, two combinational reads, one clocked write.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module register_file #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  reg_write,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  // x0 has no storage; the array starts at index 1
  logic [DATA_WIDTH-1:0] regs_q [DEPTH-1:1];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH-1:1];
  logic                  wr_en_c;

  assign wr_en_c = reg_write && !reset && (rd != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en_c) begin
      regs_d[rd] = write_data;
    end
  end

  // Reset has priority over a same-edge write
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    read_data1 = '0;
    if (rs1 != '0) begin
`ifdef REGFILE_BYPASS_EN
      if (wr_en_c && (rs1 == rd)) begin
        read_data1 = write_data;
      end else begin
        read_data1 = regs_q[rs1];
      end
`else
      read_data1 = regs_q[rs1];
`endif
    end
  end

  always_comb begin
    read_data2 = '0;
    if (rs2 != '0) begin
`ifdef REGFILE_BYPASS_EN
      if (wr_en_c && (rs2 == rd)) begin
        read_data2 = write_data;
      end else begin
        read_data2 = regs_q[rs2];
      end
`else
      read_data2 = regs_q[rs2];
`endif
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Directed, table-driven bench for register_file; expected values are hand-computed.
// Same-cycle forwarding expectations follow REGFILE_BYPASS_EN.
module tb_register_file;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] rs1, rs2, rd;
  logic [DW-1:0] write_data;
  logic          reg_write;
  logic [DW-1:0] read_data1, read_data2;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .write_data (write_data),
    .reg_write  (reg_write),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic          rst;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [DW-1:0] exp1;
    logic [DW-1:0] exp2;
  } vec_t;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  vec_t vecs [10];

  initial begin
    logic [DW-1:0] exp_fwd;

    vecs[0] = '{"reset",         1'b1, 1'b0, 5'd0,  32'h0,        5'd5,  5'd31, 32'h0,        32'h0};
    vecs[1] = '{"wr_x1",         1'b0, 1'b1, 5'd1,  32'd100,      5'd1,  5'd0,  32'd100,      32'h0};
    vecs[2] = '{"wr_x2",         1'b0, 1'b1, 5'd2,  32'd200,      5'd1,  5'd2,  32'd100,      32'd200};
    vecs[3] = '{"wr_x0",         1'b0, 1'b1, 5'd0,  32'd300,      5'd0,  5'd1,  32'h0,        32'd100};
    vecs[4] = '{"hold",          1'b0, 1'b0, 5'd0,  32'h0,        5'd2,  5'd0,  32'd200,      32'h0};
    vecs[5] = '{"we0_a",         1'b0, 1'b0, 5'd3,  32'hDEADBEEF, 5'd3,  5'd3,  32'h0,        32'h0};
    vecs[6] = '{"we0_b",         1'b0, 1'b0, 5'd3,  32'hDEADBEEF, 5'd3,  5'd2,  32'h0,        32'd200};
    vecs[7] = '{"wr_x31",        1'b0, 1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd1,  32'hFFFFFFFF, 32'd100};
    vecs[8] = '{"rst_priority",  1'b1, 1'b1, 5'd1,  32'd555,      5'd1,  5'd2,  32'h0,        32'h0};
    vecs[9] = '{"first_wr",      1'b0, 1'b1, 5'd1,  32'h12345678, 5'd1,  5'd31, 32'h12345678, 32'h0};

    reset = 1'b1; reg_write = 1'b0; rd = '0; write_data = '0; rs1 = '0; rs2 = '0;
    #2;

    for (int i = 0; i < 10; i++) begin
      reset = vecs[i].rst; reg_write = vecs[i].we; rd = vecs[i].wa; write_data = vecs[i].wd;
      @(posedge clk); #1;
      reset = 1'b0; reg_write = 1'b0;
      rs1 = vecs[i].ra1; rs2 = vecs[i].ra2;
      #1;
      check({vecs[i].name, ".rd1"}, read_data1, vecs[i].exp1);
      check({vecs[i].name, ".rd2"}, read_data2, vecs[i].exp2);
    end

    // Same-cycle read/write of x4 on both ports
`ifdef REGFILE_BYPASS_EN
    exp_fwd = 32'd77;
`else
    exp_fwd = 32'd0;
`endif
    rs1 = 5'd4; rs2 = 5'd4; rd = 5'd4; write_data = 32'd77; reg_write = 1'b1;
    #1;
    check("same_cycle.pre1", read_data1, exp_fwd);
    check("same_cycle.pre2", read_data2, exp_fwd);
    @(posedge clk); #1;
    check("same_cycle.post1", read_data1, 32'd77);
    check("same_cycle.post2", read_data2, 32'd77);

    // Disabled write to the read address must not forward
    write_data = 32'd99; reg_write = 1'b0;
    #1;
    check("no_we_fwd", read_data1, 32'd77);
    @(posedge clk); #1;
    check("no_we_hold", read_data1, 32'd77);

    // Write to x0 while reading x0 must still read zero
    rs1 = 5'd0; rd = 5'd0; write_data = 32'h5; reg_write = 1'b1;
    #1;
    check("x0_fwd", read_data1, 32'h0);
    @(posedge clk); #1;
    reg_write = 1'b0;

    // Reset with a pending write: no forwarding, stored value until the edge, zero after
    rs1 = 5'd4; rs2 = 5'd1; rd = 5'd4; write_data = 32'd123; reg_write = 1'b1; reset = 1'b1;
    #1;
    check("rst_fwd.pre", read_data1, 32'd77);
    @(posedge clk); #1;
    reset = 1'b0; reg_write = 1'b0;
    #1;
    check("rst_fwd.post1", read_data1, 32'h0);
    check("rst_fwd.post2", read_data2, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
